// File: rtl/time_tag_decoder_pkg.sv
// Time tag word layout shared by the decoder and the tag generator.
// Field positions, framing constant, word classification and tag builder.
package time_tag_decoder_pkg;

    localparam int WORD_W     = 128;

    localparam int FRAME_HI   = 127;
    localparam int FRAME_LO   = 123;
    localparam int FRAME_W    = FRAME_HI - FRAME_LO + 1;
    localparam logic [FRAME_W-1:0] FRAME_PAT = 5'b11111;

    localparam int SINGLE_BIT = 122;

    localparam int MOD_HI     = 121;
    localparam int MOD_LO     = 118;
    localparam int MOD_W      = MOD_HI - MOD_LO + 1;

    localparam int BLK_HI     = 117;
    localparam int BLK_LO     = 116;
    localparam int BLK_W      = BLK_HI - BLK_LO + 1;

    localparam int CMD_BIT    = 115;

    localparam int RSV_HI     = 114;
    localparam int RSV_LO     = 48;
    localparam int RSV_W      = RSV_HI - RSV_LO + 1;

    localparam int PER_HI     = 47;
    localparam int PER_LO     = 0;
    localparam int PER_W      = PER_HI - PER_LO + 1;

    // What the decoder does with an accepted word.
    typedef enum logic [1:0] {
        WK_UNFRAMED,
        WK_DATA,
        WK_TAG,
        WK_MALFORMED
    } word_kind_t;

    // Framing wins over everything; any framed word carrying the single or
    // command flag is ordinary event data; only then is the reserved field
    // inspected.
    function automatic word_kind_t classify(input logic [WORD_W-1:0] w);
        word_kind_t k;
        if (w[FRAME_HI:FRAME_LO] != FRAME_PAT) begin
            k = WK_UNFRAMED;
        end else if (w[SINGLE_BIT] || w[CMD_BIT]) begin
            k = WK_DATA;
        end else if (|w[RSV_HI:RSV_LO]) begin
            k = WK_MALFORMED;
        end else begin
            k = WK_TAG;
        end
        return k;
    endfunction

    // Builds a well-formed time tag word (block ID zero).
    function automatic logic [WORD_W-1:0] make_tag(
        input logic [MOD_W-1:0] id,
        input logic [PER_W-1:0] per
    );
        logic [WORD_W-1:0] w;
        w                    = '0;
        w[FRAME_HI:FRAME_LO] = FRAME_PAT;
        w[MOD_HI:MOD_LO]     = id;
        w[PER_HI:PER_LO]     = per;
        return w;
    endfunction

endpackage

// File: rtl/time_tag_decoder_tracker.sv
// Per-module continuity tracker: seen flag and last period per module ID.
// Ports: clk, rst_n, upd (commit a tag), mod_id, period in; gap out (comb).
module tag_continuity_tracker
    import time_tag_decoder_pkg::*;
#(
    parameter int NUM_MOD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd,
    input  logic [MOD_W-1:0] mod_id,
    input  logic [PER_W-1:0] period,
    output logic             gap
);

    logic [NUM_MOD-1:0] seen;
    logic [PER_W-1:0]   last [NUM_MOD];
    logic [PER_W-1:0]   expect_per;

    // 48-bit add wraps naturally, so all-ones followed by zero is continuous.
    assign expect_per = last[mod_id] + PER_W'(1);
    assign gap        = seen[mod_id] && (period != expect_per);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen <= '0;
        end else if (upd) begin
            seen[mod_id] <= 1'b1;
        end
    end

    // last[] is meaningless until seen[] is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (upd) begin
            last[mod_id] <= period;
        end
    end

endmodule

// File: rtl/time_tag_decoder.sv
// Splits a 128-bit word stream into forwarded event words and time tags.
// Ports: s_* upstream handshake, m_* downstream slice, tt_* tag pulse, error counters.
module time_tag_decoder
    import time_tag_decoder_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int NUM_MOD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [127:0]      s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [127:0]      m_data,
    output logic              tt_valid,
    output logic [3:0]        tt_module,
    output logic [47:0]       tt_period,
    output logic              tt_gap,
    output logic [CNT_W-1:0]  frame_err_cnt,
    output logic [CNT_W-1:0]  malformed_cnt,
    output logic [CNT_W-1:0]  gap_cnt
);

    word_kind_t       kind;
    logic             accept;
    logic             fwd_evt;
    logic             tag_ok;
    logic             frame_evt;
    logic             malf_evt;
    logic             tag_gap;
    logic [MOD_W-1:0] tag_id;
    logic [PER_W-1:0] tag_per;

    // One-deep slice: a new word may enter whenever the held one leaves.
    assign s_ready   = ~m_valid | m_ready;
    assign accept    = s_valid & s_ready;

    assign kind      = classify(s_data);
    assign tag_id    = s_data[MOD_HI:MOD_LO];
    assign tag_per   = s_data[PER_HI:PER_LO];

    assign fwd_evt   = accept && (kind == WK_DATA);
    assign tag_ok    = accept && (kind == WK_TAG);
    assign frame_evt = accept && (kind == WK_UNFRAMED);
    assign malf_evt  = accept && (kind == WK_MALFORMED);

    tag_continuity_tracker #(
        .NUM_MOD (NUM_MOD)
    ) u_tracker (
        .clk     (clk),
        .rst_n   (rst_n),
        .upd     (tag_ok),
        .mod_id  (tag_id),
        .period  (tag_per),
        .gap     (tag_gap)
    );

    // Output slice valid; reset drops any held word without a handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
        end else if (fwd_evt) begin
            m_valid <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fwd_evt) begin
            m_data <= s_data;
        end
    end

    // Tag result registers; module/period hold between tags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tt_valid  <= 1'b0;
            tt_gap    <= 1'b0;
            tt_module <= '0;
            tt_period <= '0;
        end else begin
            tt_valid <= tag_ok;
            tt_gap   <= tag_ok & tag_gap;
            if (tag_ok) begin
                tt_module <= tag_id;
                tt_period <= tag_per;
            end
        end
    end

    // Saturating event counters; one accept per cycle keeps them exclusive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err_cnt <= '0;
            malformed_cnt <= '0;
            gap_cnt       <= '0;
        end else begin
            if (frame_evt && !(&frame_err_cnt)) begin
                frame_err_cnt <= frame_err_cnt + CNT_W'(1);
            end
            if (malf_evt && !(&malformed_cnt)) begin
                malformed_cnt <= malformed_cnt + CNT_W'(1);
            end
            if (tag_ok && tag_gap && !(&gap_cnt)) begin
                gap_cnt <= gap_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_time_tag_decoder.sv
// Bench for time_tag_decoder: directed cases plus random traffic.
// A word-level reference model predicts every output on every cycle.
module tb_time_tag_decoder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [127:0] s_data = '0;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [127:0] m_data;
    logic         tt_valid;
    logic [3:0]   tt_module;
    logic [47:0]  tt_period;
    logic         tt_gap;
    logic [15:0]  frame_err_cnt;
    logic [15:0]  malformed_cnt;
    logic [15:0]  gap_cnt;

    time_tag_decoder #(
        .CNT_W   (16),
        .NUM_MOD (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .tt_valid      (tt_valid),
        .tt_module     (tt_module),
        .tt_period     (tt_period),
        .tt_gap        (tt_gap),
        .frame_err_cnt (frame_err_cnt),
        .malformed_cnt (malformed_cnt),
        .gap_cnt       (gap_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [127:0] fwdq[$];
    logic         armed = 1'b0;
    logic         e_ttv, e_gap;
    logic [3:0]   e_mod;
    logic [47:0]  e_per;
    logic [15:0]  e_fe, e_ml, e_gc;
    logic         seen_m [16];
    logic [47:0]  last_m [16];

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    initial begin
        logic       rdy;
        logic [3:0] id;
        logic [47:0] per;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                fwdq.delete();
                e_ttv = 0; e_gap = 0; e_mod = 0; e_per = 0;
                e_fe = 0; e_ml = 0; e_gc = 0;
                for (int i = 0; i < 16; i++) seen_m[i] = 0;
                armed = 1;
            end else begin
                rdy = (fwdq.size() == 0) || m_ready;
                if (fwdq.size() != 0 && m_ready) void'(fwdq.pop_front());
                e_ttv = 0;
                if (s_valid && rdy) begin
                    if (s_data[127:123] != 5'b11111) begin
                        e_fe = sat(e_fe);
                    end else if (s_data[122] || s_data[115]) begin
                        fwdq.push_back(s_data);
                    end else if (s_data[114:48] != '0) begin
                        e_ml = sat(e_ml);
                    end else begin
                        id  = s_data[121:118];
                        per = s_data[47:0];
                        e_ttv = 1;
                        e_mod = id;
                        e_per = per;
                        e_gap = seen_m[id] && (per != last_m[id] + 48'd1);
                        if (e_gap) e_gc = sat(e_gc);
                        seen_m[id] = 1;
                        last_m[id] = per;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int   obs_tt = 0;
    int   obs_fwd = 0;
    logic obs_gap = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("s_ready", s_ready, (fwdq.size() == 0) || m_ready);
                chk("m_valid", m_valid, fwdq.size() != 0);
                if (fwdq.size() != 0) chk("m_data", m_data, fwdq[0]);
                chk("tt_valid", tt_valid, e_ttv);
                chk("tt_module", tt_module, e_mod);
                chk("tt_period", tt_period, e_per);
                if (e_ttv) chk("tt_gap", tt_gap, e_gap);
                chk("frame_err_cnt", frame_err_cnt, e_fe);
                chk("malformed_cnt", malformed_cnt, e_ml);
                chk("gap_cnt", gap_cnt, e_gc);
                if (tt_valid) begin
                    obs_tt++;
                    obs_gap = tt_gap;
                end
                if (m_valid && m_ready) obs_fwd++;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic rand_mr = 1'b0;

    task automatic step();
        @(posedge clk);
        #2;
        if (rand_mr) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        s_valid = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_acc();
        int   n;
        logic rdy;
        n = 0;
        do begin
            @(negedge clk);
            rdy = s_ready;
            step();
            n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no s_ready want s_ready");
        end
        s_valid = 0;
    endtask

    task automatic send(input logic [127:0] w);
        s_valid = 1;
        s_data  = w;
        wait_acc();
    endtask

    function automatic logic [127:0] mk(
        input logic [4:0] fr, input logic sg, input logic [3:0] id,
        input logic [1:0] bk, input logic cm, input logic [66:0] rsv,
        input logic [47:0] per);
        return {fr, sg, id, bk, cm, rsv, per};
    endfunction

    function automatic logic [127:0] tag(input logic [3:0] id,
                                         input logic [47:0] per);
        return mk(5'b11111, 1'b0, id, 2'b00, 1'b0, 67'd0, per);
    endfunction

    int           t0, f0;
    logic [127:0] w1, w2, w3;
    logic [47:0]  prev_per [16];

    initial begin
        for (int i = 0; i < 16; i++) prev_per[i] = 0;
        idle(3);
        rst_n = 1;
        @(negedge clk);
        chk("rst s_ready", s_ready, 1'b1);
        chk("rst m_valid", m_valid, 1'b0);
        chk("rst tt_valid", tt_valid, 1'b0);
        chk("rst tt_module", tt_module, 4'd0);
        chk("rst tt_period", tt_period, 48'd0);
        chk("rst counters", {frame_err_cnt, malformed_cnt, gap_cnt}, 48'd0);
        step();

        // module 3: 0,1,2 continuous
        t0 = obs_tt;
        send(tag(4'd3, 48'd0));
        send(tag(4'd3, 48'd1));
        send(tag(4'd3, 48'd2));
        idle(2);
        chk("m3 pulses", obs_tt - t0, 3);
        chk("m3 last gap", obs_gap, 1'b0);
        chk("m3 gap_cnt", gap_cnt, 16'd0);

        // module 5: 10,12 gap then 13 continuous
        send(tag(4'd5, 48'd10));
        send(tag(4'd5, 48'd12));
        idle(2);
        chk("m5 12 gap", obs_gap, 1'b1);
        chk("m5 gap_cnt", gap_cnt, 16'd1);
        send(tag(4'd5, 48'd13));
        idle(2);
        chk("m5 13 gap", obs_gap, 1'b0);

        // module 1: wrap-around
        send(tag(4'd1, 48'hFFFF_FFFF_FFFF));
        send(tag(4'd1, 48'd0));
        idle(2);
        chk("m1 wrap gap", obs_gap, 1'b0);
        chk("m1 wrap gap_cnt", gap_cnt, 16'd1);

        // bad framing, then malformed tag
        t0 = obs_tt;
        f0 = obs_fwd;
        send(mk(5'b01111, 1'b0, 4'd2, 2'b00, 1'b0, 67'd0, 48'd7));
        idle(2);
        chk("frame_err_cnt", frame_err_cnt, 16'd1);
        chk("unframed no tt", obs_tt - t0, 0);
        chk("unframed no fwd", obs_fwd - f0, 0);
        send(tag(4'd5, 48'd20) | (128'd1 << 60));
        idle(2);
        chk("malformed_cnt", malformed_cnt, 16'd1);
        chk("malformed no tt", obs_tt - t0, 0);
        send(tag(4'd5, 48'd14));
        idle(2);
        chk("after malformed gap", obs_gap, 1'b0);

        // backpressure with single-event words
        f0 = obs_fwd;
        w1 = mk(5'b11111, 1'b1, 4'd9, 2'b10, 1'b0, 67'h5A5A, 48'h1234);
        w2 = mk(5'b11111, 1'b1, 4'd6, 2'b01, 1'b1, 67'h0F0F, 48'h9876);
        m_ready = 0;
        send(w1);
        s_valid = 1;
        s_data  = w2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall s_ready", s_ready, 1'b0);
            chk("stall m_data", m_data, w1);
            step();
        end
        m_ready = 1;
        wait_acc();
        idle(3);
        chk("stall fwd count", obs_fwd - f0, 2);

        // reset while a word is held
        m_ready = 0;
        w3 = mk(5'b11111, 1'b0, 4'd4, 2'b00, 1'b1, 67'd0, 48'd55);
        send(w3);
        rst_n = 0;
        step();
        rst_n = 1;
        @(negedge clk);
        chk("mid rst m_valid", m_valid, 1'b0);
        chk("mid rst counters", {frame_err_cnt, malformed_cnt, gap_cnt}, 48'd0);
        step();
        m_ready = 1;
        t0 = obs_tt;
        send(tag(4'd5, 48'd100));
        idle(2);
        chk("post rst pulse", obs_tt - t0, 1);
        chk("post rst gap", obs_gap, 1'b0);

        // random traffic
        rand_mr = 1;
        for (int n = 0; n < 600; n++) begin
            int          k;
            logic [3:0]  id;
            logic [47:0] p;
            logic [66:0] rv;
            logic [4:0]  fr;
            logic [127:0] w;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            k  = $urandom_range(0, 99);
            id = 4'($urandom_range(0, 15));
            if (k < 40) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: p = prev_per[id] + 48'd1;
                    5:             p = prev_per[id];
                    6:             p = 48'hFFFF_FFFF_FFFF;
                    default:       p = {16'($urandom), $urandom};
                endcase
                prev_per[id] = p;
                w = tag(id, p);
            end else if (k < 50) begin
                rv = 67'd1 << $urandom_range(0, 66);
                w = mk(5'b11111, 1'b0, id, 2'b00, 1'b0, rv,
                       {16'($urandom), $urandom});
            end else if (k < 65) begin
                fr = 5'($urandom_range(0, 30));
                w = {fr, 27'($urandom), $urandom, $urandom, $urandom};
            end else begin
                w = {5'b11111, 27'($urandom), $urandom, $urandom, $urandom};
                if (!w[122] && !w[115]) w[115] = 1'b1;
            end
            send(w);
        end
        rand_mr = 0;
        m_ready = 1;
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
